// File: rtl/adpll_gear_controller.sv
// adpll_gear_controller: loop-bandwidth gear shifter for the ADPLL random-walk filter
module adpll_gear_controller #(
  parameter int WindowLength     = 256,
  parameter int WindowWidth      = 16,
  parameter int Gear0Length      = 8,
  parameter int Gear1Length      = 16,
  parameter int Gear2Length      = 32,
  parameter int Gear3Length      = 64,
  parameter int QuietThreshold   = 2,
  parameter int BalanceThreshold = 1,
  parameter int BusyThreshold    = 8,
  parameter int QuietWindows     = 4,
  parameter int SettleCycles     = 16
) (
  input  logic       i_main_clock,
  input  logic       i_n_reset,
  input  logic       i_enable,
  input  logic       i_positive,
  input  logic       i_negative,
  output logic [7:0] o_filter_length,
  output logic [1:0] o_gear,
  output logic       o_gear_change,
  output logic       o_locked
);
  localparam int QW = $clog2(QuietWindows + 1);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_COUNT  = 2'd1;
  localparam logic [1:0] S_EVAL   = 2'd2;
  localparam logic [1:0] S_SETTLE = 2'd3;

  logic [1:0]             r_state, w_state_nxt;
  logic [WindowWidth-1:0] r_win, w_win_nxt;
  logic [7:0]             r_total, w_total_nxt, w_total_acc, w_abs_net;
  logic signed [7:0]      r_net, w_net_nxt, w_net_acc;
  logic [QW-1:0]          r_quiet, w_quiet_nxt, w_quiet_inc;
  logic [1:0]             r_gear, w_gear_nxt;
  logic                   r_gear_change, w_gear_change_nxt;
  logic [8:0]             w_total_sum;
  logic                   w_busy, w_quiet, w_quiet_full, w_win_last, w_settle_last;

  assign w_total_sum   = {1'b0, r_total} + {8'd0, i_positive} + {8'd0, i_negative};
  assign w_total_acc   = w_total_sum[8] ? 8'hFF : w_total_sum[7:0];
  assign w_net_acc     = (i_positive & ~i_negative & (r_net != 8'sd127))  ? r_net + 8'sd1 :
                         (i_negative & ~i_positive & (r_net != -8'sd128)) ? r_net - 8'sd1 : r_net;
  assign w_abs_net     = r_net[7] ? (~r_net + 8'd1) : r_net;
  assign w_busy        = r_total >= 8'(BusyThreshold);
  assign w_quiet       = (r_total <= 8'(QuietThreshold)) && (w_abs_net <= 8'(BalanceThreshold));
  assign w_quiet_inc   = r_quiet + QW'(1);
  assign w_quiet_full  = w_quiet_inc >= QW'(QuietWindows);
  assign w_win_last    = r_win == WindowWidth'(WindowLength - 1);
  assign w_settle_last = r_win == WindowWidth'(SettleCycles - 1);

  // next-state: window accumulation, end-of-window gear decision, settle hold-off
  always_comb begin
    w_state_nxt       = r_state;
    w_win_nxt         = r_win;
    w_total_nxt       = r_total;
    w_net_nxt         = r_net;
    w_quiet_nxt       = r_quiet;
    w_gear_nxt        = r_gear;
    w_gear_change_nxt = 1'b0;
    if (!i_enable) begin
      w_state_nxt = S_IDLE;
      w_win_nxt   = '0;
      w_total_nxt = '0;
      w_net_nxt   = '0;
      w_quiet_nxt = '0;
      w_gear_nxt  = 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_COUNT;
          w_win_nxt   = '0;
          w_total_nxt = '0;
          w_net_nxt   = '0;
        end
        S_COUNT: begin
          w_total_nxt = w_total_acc;
          w_net_nxt   = w_net_acc;
          w_win_nxt   = w_win_last ? '0 : r_win + WindowWidth'(1);
          w_state_nxt = w_win_last ? S_EVAL : S_COUNT;
        end
        S_EVAL: begin
          w_total_nxt = '0;
          w_net_nxt   = '0;
          w_win_nxt   = '0;
          w_state_nxt = S_COUNT;
          if (w_busy) begin
            w_quiet_nxt = '0;
            if (r_gear != 2'd0) begin
              w_gear_nxt        = r_gear - 2'd1;
              w_gear_change_nxt = 1'b1;
              w_state_nxt       = S_SETTLE;
            end
          end else if (w_quiet) begin
            if (w_quiet_full && r_gear != 2'd3) begin
              w_gear_nxt        = r_gear + 2'd1;
              w_quiet_nxt       = '0;
              w_gear_change_nxt = 1'b1;
              w_state_nxt       = S_SETTLE;
            end else begin
              w_quiet_nxt = w_quiet_full ? QW'(QuietWindows) : w_quiet_inc;
            end
          end else begin
            w_quiet_nxt = '0;
          end
        end
        default: begin
          w_win_nxt   = w_settle_last ? '0 : r_win + WindowWidth'(1);
          w_state_nxt = w_settle_last ? S_COUNT : S_SETTLE;
        end
      endcase
    end
  end

  // state registers, cleared asynchronously
  always_ff @(posedge i_main_clock or negedge i_n_reset) begin
    if (!i_n_reset) begin
      r_state       <= S_IDLE;
      r_win         <= '0;
      r_total       <= '0;
      r_net         <= '0;
      r_quiet       <= '0;
      r_gear        <= 2'd0;
      r_gear_change <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_win         <= w_win_nxt;
      r_total       <= w_total_nxt;
      r_net         <= w_net_nxt;
      r_quiet       <= w_quiet_nxt;
      r_gear        <= w_gear_nxt;
      r_gear_change <= w_gear_change_nxt;
    end
  end

  // filter length is a straight table lookup of the registered gear
  always_comb begin
    o_filter_length = r_gear == 2'd0 ? 8'(Gear0Length) :
                      r_gear == 2'd1 ? 8'(Gear1Length) :
                      r_gear == 2'd2 ? 8'(Gear2Length) : 8'(Gear3Length);
  end

  assign o_gear        = r_gear;
  assign o_gear_change = r_gear_change;
  assign o_locked      = (r_gear == 2'd3) && (r_state != S_IDLE);
endmodule

// File: tb/tb_adpll_gear_controller.sv
// tb_adpll_gear_controller: randomized windows against a window-level gear model with a gear-change scoreboard
`timescale 1ns/1ps
module tb_adpll_gear_controller;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       pos = 1'b0;
  logic       neg = 1'b0;
  logic [7:0] o_filter_length;
  logic [1:0] o_gear;
  logic       o_gear_change;
  logic       o_locked;

  adpll_gear_controller dut (
    .i_main_clock(clk),
    .i_n_reset(rst_n),
    .i_enable(en),
    .i_positive(pos),
    .i_negative(neg),
    .o_filter_length(o_filter_length),
    .o_gear(o_gear),
    .o_gear_change(o_gear_change),
    .o_locked(o_locked)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int gear;} exp_t;
  exp_t sb[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int m_gear = 0;
  int m_quiet = 0;
  int fl_tab[4] = '{8, 16, 32, 64};
  bit pa[256];
  bit na[256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every gear-change pulse must match the oldest expected change
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && o_gear_change) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL gc_stray got pulse at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("gc_cycle", cyc, e.cyc);
        chk("gc_gear", int'(o_gear), e.gear);
        chk("gc_fl", int'(o_filter_length), fl_tab[e.gear]);
        chk("gc_locked", int'(o_locked), int'(e.gear == 3));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic step(input logic p, input logic n);
    pos = p;
    neg = n;
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_step();
    step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic place(input int cnt, input bit p, input bit n);
    int idx;
    for (int k = 0; k < cnt; k++) begin
      idx = $urandom_range(0, 255);
      while (pa[idx] || na[idx]) idx = $urandom_range(0, 255);
      pa[idx] = p;
      na[idx] = n;
    end
  endtask

  task automatic fill(input int np, input int nn, input int nb);
    for (int i = 0; i < 256; i++) begin
      pa[i] = 1'b0;
      na[i] = 1'b0;
    end
    place(nb, 1'b1, 1'b1);
    place(np, 1'b1, 1'b0);
    place(nn, 1'b0, 1'b1);
  endtask

  task automatic model_reset();
    m_gear = 0;
    m_quiet = 0;
  endtask

  task automatic decide(input int tot, input int net, output bit ch);
    ch = 1'b0;
    if (tot >= 8) begin
      m_quiet = 0;
      if (m_gear > 0) begin
        m_gear--;
        ch = 1'b1;
      end
    end else if (tot <= 2 && (net < 0 ? -net : net) <= 1) begin
      m_quiet++;
      if (m_quiet >= 4) begin
        if (m_gear < 3) begin
          m_gear++;
          m_quiet = 0;
          ch = 1'b1;
        end else m_quiet = 4;
      end
    end else m_quiet = 0;
  endtask

  task automatic run_window(input int settle_steps);
    int tot = 0;
    int net = 0;
    bit ch;
    exp_t e;
    for (int i = 0; i < 256; i++) begin
      tot += int'(pa[i]) + int'(na[i]);
      net += int'(pa[i]) - int'(na[i]);
      net = net > 127 ? 127 : net < -128 ? -128 : net;
      step(pa[i], na[i]);
    end
    tot = tot > 255 ? 255 : tot;
    rnd_step();
    decide(tot, net, ch);
    if (ch) begin
      e.cyc = cyc;
      e.gear = m_gear;
      sb.push_back(e);
    end
    chk("gear", int'(o_gear), m_gear);
    chk("fl", int'(o_filter_length), fl_tab[m_gear]);
    chk("locked", int'(o_locked), int'(m_gear == 3));
    chk("gc", int'(o_gear_change), int'(ch));
    if (ch) for (int i = 0; i < settle_steps; i++) rnd_step();
  endtask

  task automatic quiet_window();
    fill($urandom_range(0, 1), $urandom_range(0, 1), 0);
    run_window(16);
  endtask

  task automatic restart();
    en = 1'b0;
    step(1'b0, 1'b0);
    model_reset();
    en = 1'b1;
    step(1'b0, 1'b0);
  endtask

  initial begin
    #12;
    chk("rst_gear", int'(o_gear), 0);
    chk("rst_fl", int'(o_filter_length), 8);
    chk("rst_gc", int'(o_gear_change), 0);
    chk("rst_locked", int'(o_locked), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) rnd_step();
    chk("idle_gear", int'(o_gear), 0);
    chk("idle_locked", int'(o_locked), 0);
    en = 1'b1;
    step(1'b0, 1'b0);
    for (int w = 0; w < 12; w++) begin
      fill(0, 0, 0);
      run_window(16);
    end
    chk("acq_locked", int'(o_locked), 1);
    fill(8 + $urandom_range(0, 4), 0, 0);
    run_window(16);
    for (int w = 0; w < 3; w++) quiet_window();
    fill(2, 0, 0);
    run_window(16);
    for (int w = 0; w < 4; w++) quiet_window();
    for (int w = 0; w < 2; w++) quiet_window();
    fill(0, 8 + $urandom_range(0, 3), 0);
    run_window(5);
    en = 1'b0;
    step(1'b0, 1'b0);
    model_reset();
    chk("dis_gear", int'(o_gear), 0);
    chk("dis_fl", int'(o_filter_length), 8);
    chk("dis_gc", int'(o_gear_change), 0);
    chk("dis_locked", int'(o_locked), 0);
    step(1'b0, 1'b0);
    en = 1'b1;
    step(1'b0, 1'b0);
    fill(0, 0, 0);
    for (int i = 0; i < 200; i++) begin
      pa[i] = 1'b1;
      na[i] = 1'b1;
    end
    run_window(16);
    for (int w = 0; w < 20; w++) begin
      case ($urandom_range(0, 3))
        0: fill($urandom_range(0, 1), $urandom_range(0, 1), 0);
        1: fill($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1));
        2: fill($urandom_range(4, 10), $urandom_range(0, 2), $urandom_range(0, 2));
        default: fill(0, 0, 0);
      endcase
      run_window(16);
    end
    restart();
    for (int w = 0; w < 8; w++) quiet_window();
    chk("pre_rst_gear", int'(o_gear), 2);
    for (int i = 0; i < 100; i++) rnd_step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gear", int'(o_gear), 0);
    chk("arst_fl", int'(o_filter_length), 8);
    chk("arst_gc", int'(o_gear_change), 0);
    chk("arst_locked", int'(o_locked), 0);
    model_reset();
    en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
